wb_sequencer: RTL and testbench
===============================

Name: wb_sequencer

Overview:
Sequences the register-file writeback stage of the 34-bit core, in front of the writeback source mux.
- Classifies each issued instruction by source (ALU, shift, stack, memory, set-immediate).
- Runs the multi-cycle memory and stack handshakes.
- Drives the mux source select, register-file write enable and write address.
- Stalls issue while busy, and raises a sticky fault on stack underflow or memory timeout.

Parameters:
C_WIDTH, 4, control code width
I_WIDTH, 17, full instruction width
R_WIDTH, 4, register address width
MEM_TIMEOUT, 15, maximum MEM_WAIT cycles before fault (1..255)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous, active-low reset
issue_valid_i  input  1  instruction offered for writeback
issue_ready_o  output  1  sequencer can accept an instruction
control_i  input  C_WIDTH  control code of the offered instruction
instruction_full_i  input  I_WIDTH  full instruction word
rd_addr_i  input  R_WIDTH  destination register
mem_req_o  output  1  memory read request, level
mem_ack_i  input  1  memory data valid, single-cycle pulse
stack_pop_o  output  1  stack pop strobe, single cycle
stack_valid_i  input  1  stack data valid
stack_empty_i  input  1  stack empty flag
sel_o  output  3  writeback source select (src_e)
rf_we_o  output  1  register-file write enable
rf_waddr_o  output  R_WIDTH  register-file write address
stall_o  output  1  upstream stall
fault_o  output  1  sticky fault flag
fault_clear_i  input  1  clears a fault

Behaviour:
- Reset is asynchronous on rst_n low. While and after reset:
  - State is IDLE.
  - mem_req_o, stack_pop_o, rf_we_o, stall_o and fault_o are 0.
  - sel_o is SRC_SET, rf_waddr_o is 0, the timeout counter is 0.
  - issue_ready_o is 1.
- Classification uses this priority:
  - control_i in {1,2,3,4,5,6,11} -> SRC_ALU.
  - control_i === 14 -> SRC_SHIFT. An X/Z control does not match.
  - instruction_full_i[I_WIDTH-1:I_WIDTH-7] == 7'b1111110 -> SRC_STACK.
  - control_i == 7 -> SRC_MEM.
  - Otherwise -> SRC_SET.
- Outputs are decoded from the state and from the latched sel/waddr registers.
  - issue_ready_o = (state==IDLE).
  - stall_o = !issue_ready_o.
- Handshake: an instruction is accepted when issue_valid_i && issue_ready_o on a clock edge. On acceptance, sel and rd_addr_i are latched.
- States and transitions:
  - IDLE, accept ALU/SHIFT/SET -> WRITE. Latency from accept to the rf_we_o cycle is 1.
  - IDLE, accept MEM -> MEM_WAIT. The counter is cleared.
  - IDLE, accept STACK with stack_empty_i=1 -> FAULT. No pop is issued.
  - IDLE, accept STACK with stack_empty_i=0 -> STACK_WAIT. stack_pop_o is high for exactly the first STACK_WAIT cycle.
  - MEM_WAIT: mem_req_o=1 and the counter increments every cycle.
    - mem_ack_i -> WRITE.
    - Otherwise, counter==MEM_TIMEOUT-1 -> FAULT.
    - If ack and timeout occur in the same cycle, ack wins.
  - STACK_WAIT: stack_valid_i -> WRITE. A valid arriving in the pop cycle is accepted. There is no timeout.
  - WRITE: rf_we_o=1 for exactly one cycle, with sel_o/rf_waddr_o stable -> IDLE.
  - FAULT: fault_o=1 and issue_ready_o=0. fault_clear_i -> IDLE. No write is performed for the faulting instruction.
- Throughput: single-cycle-source instructions retire one per 2 cycles.
- sel_o and rf_waddr_o hold their last value in IDLE.
- Ignored inputs:
  - mem_ack_i outside MEM_WAIT.
  - stack_valid_i outside STACK_WAIT.
  - fault_clear_i outside FAULT.
- Reset mid-operation: mem_req_o/stack_pop_o drop immediately and the in-flight instruction is discarded.

Decomposition:
- Package wb_pkg contains:
  - typedef enum logic [2:0] src_e {SRC_ALU=0, SRC_SHIFT=1, SRC_STACK=2, SRC_MEM=3, SRC_SET=4}.
  - typedef enum state_e {IDLE, WRITE, MEM_WAIT, STACK_WAIT, FAULT}.
  - Constants: ALU control code list, CTL_SHIFT=14, CTL_MEM=7, STACK_OPC=7'b1111110.
- Sub-module wb_classify: purely combinational, control_i/instruction_full_i -> src_e. It is shared with the mux select logic.

Test Plan:
- ALU: control=4'b0011, rd=5, issued at cycle 0 -> sel_o=0, rf_we_o=1, rf_waddr_o=5 at cycle 1; issue_ready_o=1 at cycle 2.
- Memory: control=4'b0111 accepted at cycle 0, mem_ack_i pulsed at cycle 4 -> mem_req_o high cycles 1-4, rf_we_o at cycle 5 with sel_o=3.
- Memory timeout: control=7, no ack, MEM_TIMEOUT=15 -> FAULT after 15 MEM_WAIT cycles, fault_o=1, no rf_we_o. fault_clear_i returns to IDLE.
- Stack:
  - Top 7 bits 1111110, control=0, stack_empty_i=0 -> one-cycle stack_pop_o; stack_valid_i next cycle -> rf_we_o, sel_o=2.
  - Same with stack_empty_i=1 -> immediate FAULT, stack_pop_o never asserts.
- Priority/X: control=4'b0001 with top bits 1111110 -> SRC_ALU. control=4'bxxxx with top bits 0 -> SRC_SET.
- Async reset asserted during MEM_WAIT -> mem_req_o=0 before the next edge, state IDLE, issue_ready_o=1; mem_ack_i after release is ignored.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and decode constants for the writeback sequencer.
// Source codes double as the writeback mux select encoding.
package wb_pkg;

  typedef enum logic [2:0] {
    SRC_ALU   = 3'd0,
    SRC_SHIFT = 3'd1,
    SRC_STACK = 3'd2,
    SRC_MEM   = 3'd3,
    SRC_SET   = 3'd4
  } src_e;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    MEM_WAIT,
    STACK_WAIT,
    FAULT
  } state_e;

  localparam int         ALU_CTL_NUM = 7;
  localparam logic [7:0] ALU_CTLS [ALU_CTL_NUM] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd11};
  localparam logic [7:0] CTL_SHIFT = 8'd14;
  localparam logic [7:0] CTL_MEM   = 8'd7;
  localparam logic [6:0] STACK_OPC = 7'b1111110;
  localparam int         CNT_W     = 8;

endpackage

// File: rtl/wb_classify.sv
// Combinational writeback source decode, zero latency, no flow control.
// Shared by the sequencer and the writeback mux select logic.
module wb_classify
  import wb_pkg::*;
#(
  parameter int C_WIDTH = 4,
  parameter int I_WIDTH = 17
) (
  input  logic [C_WIDTH-1:0] control_i,
  input  logic [I_WIDTH-1:0] instruction_full_i,
  output src_e               src_o
);

  logic alu_hit;
  logic unused_low_bits;

  // Only the opcode field above bit I_WIDTH-8 takes part in the decode.
  assign unused_low_bits = ^instruction_full_i[I_WIDTH-8:0];

  always_comb begin
    alu_hit = 1'b0;
    for (int k = 0; k < ALU_CTL_NUM; k++) begin
      if (control_i == C_WIDTH'(ALU_CTLS[k])) alu_hit = 1'b1;
    end
  end

  // An unknown control code must never match the shift code.
  always_comb begin
    src_o = SRC_SET;
    if (alu_hit)
      src_o = SRC_ALU;
    else if (control_i === C_WIDTH'(CTL_SHIFT))
      src_o = SRC_SHIFT;
    else if (instruction_full_i[I_WIDTH-1 -: 7] == STACK_OPC)
      src_o = SRC_STACK;
    else if (control_i == C_WIDTH'(CTL_MEM))
      src_o = SRC_MEM;
  end

endmodule

// File: rtl/wb_sequencer.sv
// Writeback sequencer: accept -> rf write in 1 cycle (ALU/shift/set), memory/stack wait on handshakes.
// Backpressure: issue_ready_o only in IDLE, stall_o otherwise; faults hold until fault_clear_i.
module wb_sequencer
  import wb_pkg::*;
#(
  parameter int C_WIDTH     = 4,
  parameter int I_WIDTH     = 17,
  parameter int R_WIDTH     = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               issue_valid_i,
  output logic               issue_ready_o,
  input  logic [C_WIDTH-1:0] control_i,
  input  logic [I_WIDTH-1:0] instruction_full_i,
  input  logic [R_WIDTH-1:0] rd_addr_i,
  output logic               mem_req_o,
  input  logic               mem_ack_i,
  output logic               stack_pop_o,
  input  logic               stack_valid_i,
  input  logic               stack_empty_i,
  output logic [2:0]         sel_o,
  output logic               rf_we_o,
  output logic [R_WIDTH-1:0] rf_waddr_o,
  output logic               stall_o,
  output logic               fault_o,
  input  logic               fault_clear_i
);

  state_e             state;
  src_e               src;
  src_e               sel_q;
  logic [R_WIDTH-1:0] waddr_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               ready_q;
  logic               mem_req_q;
  logic               pop_q;
  logic               we_q;
  logic               fault_q;

  wb_classify #(
    .C_WIDTH(C_WIDTH),
    .I_WIDTH(I_WIDTH)
  ) u_classify (
    .control_i         (control_i),
    .instruction_full_i(instruction_full_i),
    .src_o             (src)
  );

  // Output flops are written alongside the next state so each one
  // reflects the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sel_q     <= SRC_SET;
      waddr_q   <= '0;
      cnt_q     <= '0;
      ready_q   <= 1'b1;
      mem_req_q <= 1'b0;
      pop_q     <= 1'b0;
      we_q      <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      ready_q   <= 1'b0;
      mem_req_q <= 1'b0;
      pop_q     <= 1'b0;
      we_q      <= 1'b0;
      fault_q   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (issue_valid_i) begin
            sel_q   <= src;
            waddr_q <= rd_addr_i;
            case (src)
              SRC_MEM: begin
                state     <= MEM_WAIT;
                cnt_q     <= '0;
                mem_req_q <= 1'b1;
              end
              SRC_STACK: begin
                if (stack_empty_i) begin
                  state   <= FAULT;
                  fault_q <= 1'b1;
                end else begin
                  state <= STACK_WAIT;
                  pop_q <= 1'b1;
                end
              end
              default: begin
                state <= WRITE;
                we_q  <= 1'b1;
              end
            endcase
          end else begin
            ready_q <= 1'b1;
          end
        end
        WRITE: begin
          state   <= IDLE;
          ready_q <= 1'b1;
        end
        MEM_WAIT: begin
          cnt_q <= cnt_q + 1'b1;
          // Ack takes precedence over a timeout landing in the same cycle.
          if (mem_ack_i) begin
            state <= WRITE;
            we_q  <= 1'b1;
          end else if (cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
            state   <= FAULT;
            fault_q <= 1'b1;
          end else begin
            mem_req_q <= 1'b1;
          end
        end
        STACK_WAIT: begin
          if (stack_valid_i) begin
            state <= WRITE;
            we_q  <= 1'b1;
          end
        end
        FAULT: begin
          if (fault_clear_i) begin
            state   <= IDLE;
            ready_q <= 1'b1;
          end else begin
            fault_q <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign issue_ready_o = ready_q;
  assign stall_o       = !ready_q;
  assign mem_req_o     = mem_req_q;
  assign stack_pop_o   = pop_q;
  assign rf_we_o       = we_q;
  assign fault_o       = fault_q;
  assign sel_o         = sel_q;
  assign rf_waddr_o    = waddr_q;

endmodule

// File: tb/tb_wb_sequencer.sv
// Directed bench for wb_sequencer: per-transaction timeline model checked every cycle,
// plus hand-computed literal pins on counts and captured write values.
module tb_wb_sequencer;
  import wb_pkg::*;

  localparam int T = 15;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid;
  logic        issue_ready;
  logic [3:0]  control;
  logic [16:0] instr;
  logic [3:0]  rd_addr;
  logic        mem_req;
  logic        mem_ack;
  logic        stack_pop;
  logic        stack_valid;
  logic        stack_empty;
  logic [2:0]  sel;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic        stall;
  logic        fault;
  logic        fault_clear;

  wb_sequencer #(
    .C_WIDTH(4), .I_WIDTH(17), .R_WIDTH(4), .MEM_TIMEOUT(T)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid_i(issue_valid), .issue_ready_o(issue_ready),
    .control_i(control), .instruction_full_i(instr), .rd_addr_i(rd_addr),
    .mem_req_o(mem_req), .mem_ack_i(mem_ack),
    .stack_pop_o(stack_pop), .stack_valid_i(stack_valid), .stack_empty_i(stack_empty),
    .sel_o(sel), .rf_we_o(rf_we), .rf_waddr_o(rf_waddr),
    .stall_o(stall), .fault_o(fault), .fault_clear_i(fault_clear)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       ready;
    logic       stall;
    logic       req;
    logic       pop;
    logic [2:0] sel;
    logic       we;
    logic [3:0] wa;
    logic       fault;
  } obs_t;

  int checks = 0;
  int errors = 0;
  int n_req = 0, n_pop = 0, n_we = 0, n_fault = 0;
  int b_req, b_pop, b_we, b_fault;
  logic [2:0] we_sel = 3'd7;
  logic [3:0] we_wa  = 4'd0;
  logic [2:0] prev_sel;
  logic [3:0] prev_wa;

  function automatic obs_t mk(bit busy, bit req, bit pop, bit we, bit flt,
                              logic [2:0] s, logic [3:0] wa);
    obs_t o;
    o.ready = !busy; o.stall = busy; o.req = req; o.pop = pop;
    o.sel = s; o.we = we; o.wa = wa; o.fault = flt;
    return o;
  endfunction

  function automatic src_e model_src(logic [3:0] c, logic [16:0] ins);
    logic [6:0] top;
    top = ins[16:10];
    if (c inside {4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd11}) return SRC_ALU;
    if (c === 4'd14) return SRC_SHIFT;
    if (top === 7'b1111110) return SRC_STACK;
    if (c === 4'd7) return SRC_MEM;
    return SRC_SET;
  endfunction

  function automatic bit faults(src_e s, bit empty, int k);
    return (s == SRC_MEM && k > T) || (s == SRC_STACK && empty);
  endfunction

  // Cycle count of one transaction: accept cycle through the last busy cycle.
  function automatic int model_len(src_e s, bit empty, int k, int clr);
    if (faults(s, empty, k)) return clr + 1;
    if (s == SRC_MEM || s == SRC_STACK) return k + 2;
    return 2;
  endfunction

  // Expected outputs i cycles after the accept cycle.
  function automatic obs_t model_at(src_e s, bit empty, int k, int i, logic [3:0] rd);
    int mend;
    if (i == 0) return mk(0, 0, 0, 0, 0, prev_sel, prev_wa);
    if (s == SRC_MEM) begin
      mend = (k <= T) ? k : T;
      if (i <= mend) return mk(1, 1, 0, 0, 0, s, rd);
      if (k <= T)    return mk(1, 0, 0, 1, 0, s, rd);
      return mk(1, 0, 0, 0, 1, s, rd);
    end
    if (s == SRC_STACK) begin
      if (empty)  return mk(1, 0, 0, 0, 1, s, rd);
      if (i <= k) return mk(1, 0, (i == 1), 0, 0, s, rd);
    end
    return mk(1, 0, 0, 1, 0, s, rd);
  endfunction

  task automatic check_cycle(input obs_t e, input string tag);
    obs_t a;
    @(negedge clk);
    a = {issue_ready, stall, mem_req, stack_pop, sel, rf_we, rf_waddr, fault};
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s t=%0t: got rdy%b stl%b req%b pop%b sel%0d we%b wa%0d flt%b, required rdy%b stl%b req%b pop%b sel%0d we%b wa%0d flt%b",
               tag, $time, a.ready, a.stall, a.req, a.pop, a.sel, a.we, a.wa, a.fault,
               e.ready, e.stall, e.req, e.pop, e.sel, e.we, e.wa, e.fault);
    end
    n_req += int'(a.req); n_pop += int'(a.pop); n_fault += int'(a.fault);
    if (a.we === 1'b1) begin
      n_we++; we_sel = a.sel; we_wa = a.wa;
    end
  endtask

  task automatic lit(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, expv);
    end
  endtask

  task automatic idle_inputs();
    issue_valid = 0; control = 0; instr = 0; rd_addr = 0;
    mem_ack = 0; stack_valid = 0; stack_empty = 0; fault_clear = 0;
  endtask

  task automatic snap();
    b_req = n_req; b_pop = n_pop; b_we = n_we; b_fault = n_fault;
  endtask

  // Drives one instruction plus ignored-input noise in every other cycle.
  task automatic run_txn(input string tag, input logic [3:0] ctl, input logic [16:0] ins,
                         input logic [3:0] rd, input bit empty, input int k, input int clr);
    src_e s;
    int   len, mend;
    bit   fp;
    s    = model_src(ctl, ins);
    len  = model_len(s, empty, k, clr);
    mend = (k <= T) ? k : T;
    fp   = faults(s, empty, k);
    snap();
    for (int i = 0; i < len; i++) begin
      if (i == 0) begin
        issue_valid = 1; control = ctl; instr = ins; rd_addr = rd; stack_empty = empty;
        mem_ack = 1; stack_valid = 1; fault_clear = 1;
      end else begin
        issue_valid = 1; control = 4'd7; instr = 17'h1FC00; rd_addr = 4'd15; stack_empty = 1;
        mem_ack     = (s == SRC_MEM) ? (i == k || i > mend) : 1'b1;
        stack_valid = (s == SRC_STACK && !empty) ? (i >= k) : 1'b1;
        fault_clear = fp ? (i == clr) : 1'b1;
      end
      check_cycle(model_at(s, empty, k, i, rd), tag);
      @(posedge clk); #1;
    end
    prev_sel = s;
    prev_wa  = rd;
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst_n = 0;
    idle_inputs();
    prev_sel = SRC_SET;
    prev_wa  = 4'd0;

    @(posedge clk); #1;
    check_cycle(mk(0, 0, 0, 0, 0, SRC_SET, 0), "reset_hold");
    @(posedge clk); #1;
    rst_n = 1;
    check_cycle(mk(0, 0, 0, 0, 0, SRC_SET, 0), "reset_release");
    @(posedge clk); #1;

    run_txn("alu", 4'b0011, 17'h0, 4'd5, 0, 0, 0);
    lit("alu_we_count", n_we - b_we, 1);
    lit("alu_waddr", int'(we_wa), 5);
    lit("alu_sel", int'(we_sel), 0);
    lit("alu_ready_c2", int'(issue_ready), 1);

    run_txn("shift", 4'd14, 17'h0, 4'd9, 0, 0, 0);
    run_txn("set", 4'd0, 17'h0, 4'd2, 0, 0, 0);
    lit("set_sel", int'(we_sel), 4);

    run_txn("mem_ack4", 4'b0111, 17'h0, 4'd6, 0, 4, 0);
    lit("mem_req_cycles", n_req - b_req, 4);
    lit("mem_sel", int'(we_sel), 3);

    run_txn("mem_ack_at_limit", 4'd7, 17'h0, 4'd7, 0, T, 0);
    lit("mem_limit_we", n_we - b_we, 1);
    lit("mem_limit_fault", n_fault - b_fault, 0);

    run_txn("mem_timeout", 4'd7, 17'h0, 4'd8, 0, 99, 18);
    lit("timeout_req_cycles", n_req - b_req, 15);
    lit("timeout_we", n_we - b_we, 0);
    lit("timeout_fault_cycles", n_fault - b_fault, 3);

    run_txn("stack_next", 4'd0, {7'b1111110, 10'h0}, 4'd10, 0, 2, 0);
    lit("stack_pops", n_pop - b_pop, 1);
    lit("stack_sel", int'(we_sel), 2);
    run_txn("stack_same", 4'd0, {7'b1111110, 10'h155}, 4'd11, 0, 1, 0);
    run_txn("stack_long", 4'd0, {7'b1111110, 10'h3FF}, 4'd12, 0, 4, 0);

    run_txn("stack_empty", 4'd0, {7'b1111110, 10'h0}, 4'd13, 1, 0, 3);
    lit("empty_pops", n_pop - b_pop, 0);
    lit("empty_we", n_we - b_we, 0);

    run_txn("prio_alu", 4'b0001, {7'b1111110, 10'h0}, 4'd1, 0, 0, 0);
    lit("prio_alu_sel", int'(we_sel), 0);
    run_txn("prio_shift", 4'd14, {7'b1111110, 10'h0}, 4'd3, 0, 0, 0);
    run_txn("prio_stack_mem", 4'd7, {7'b1111110, 10'h0}, 4'd4, 0, 1, 0);
    run_txn("ctl_x", 4'bxxxx, 17'h0, 4'd14, 0, 0, 0);
    lit("ctl_x_sel", int'(we_sel), 4);

    // Reset pulled mid MEM_WAIT, between clock edges.
    issue_valid = 1; control = 4'd7; rd_addr = 4'd3;
    check_cycle(mk(0, 0, 0, 0, 0, prev_sel, prev_wa), "rst_accept");
    @(posedge clk); #1;
    idle_inputs();
    check_cycle(mk(1, 1, 0, 0, 0, SRC_MEM, 3), "rst_memwait1");
    @(posedge clk); #1;
    check_cycle(mk(1, 1, 0, 0, 0, SRC_MEM, 3), "rst_memwait2");
    @(posedge clk); #2;
    rst_n = 0;
    #1;
    lit("rst_async_req", int'(mem_req), 0);
    lit("rst_async_ready", int'(issue_ready), 1);
    check_cycle(mk(0, 0, 0, 0, 0, SRC_SET, 0), "rst_mid");
    @(posedge clk); #1;
    check_cycle(mk(0, 0, 0, 0, 0, SRC_SET, 0), "rst_held");
    rst_n = 1;
    @(posedge clk); #1;
    mem_ack = 1;
    check_cycle(mk(0, 0, 0, 0, 0, SRC_SET, 0), "rst_late_ack");
    @(posedge clk); #1;
    mem_ack = 0;
    check_cycle(mk(0, 0, 0, 0, 0, SRC_SET, 0), "rst_after");
    @(posedge clk); #1;
    prev_sel = SRC_SET;
    prev_wa  = 4'd0;

    run_txn("alu_after_rst", 4'd11, 17'h0, 4'd15, 0, 0, 0);
    lit("alu11_waddr", int'(we_wa), 15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
